// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, lock-loss counter constants and counter width helper
package reset_seq_pkg;
  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;
  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/lock_sync_filter.sv
// lock_sync_filter: two-flop synchroniser for LOCK_IN followed by a consecutive-high stability filter
module lock_sync_filter
  import reset_seq_pkg::*;
#(
  parameter int LOCK_FILTER = 8
) (
  input  logic CLK_SLOW,
  input  logic RESET_SLOW,
  input  logic LOCK_IN,
  output logic lock_stable
);
  localparam int FW = cnt_w(LOCK_FILTER);
  logic [1:0] sync_q, sync_d;
  logic [FW-1:0] filt_q, filt_d;
  logic lock_sync;
  always_comb begin
    sync_d = {sync_q[0], LOCK_IN};
    lock_sync = sync_q[1];
    filt_d = !lock_sync ? '0 : (filt_q == FW'(LOCK_FILTER)) ? filt_q : filt_q + FW'(1);
    lock_stable = lock_sync && (filt_q >= FW'(LOCK_FILTER - 1));
  end
  always_ff @(posedge CLK_SLOW) begin
    if (RESET_SLOW) begin
      sync_q <= '0;
      filt_q <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: hold, lock-qualified, staggered release of N_CHAN resets with re-sequencing on lock loss or software request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CHAN         = 4,
  parameter int HOLD_CYCLES    = 255,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_FILTER    = 8
) (
  input  logic              CLK_SLOW,
  input  logic              RESET_SLOW,
  input  logic              LOCK_IN,
  input  logic              SW_RESET_REQ,
  output logic [N_CHAN-1:0] RESET_OUT,
  output logic              READY,
  output logic [1:0]        STATE,
  output logic [LOSS_W-1:0] LOCK_LOSS_COUNT
);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int REL_LAST = (N_CHAN - 1) * STAGGER_CYCLES;
  localparam int RW = cnt_w(REL_LAST + 1);
  if (N_CHAN < 1 || N_CHAN > 16 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || LOCK_FILTER < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [N_CHAN-1:0] rst_q, rst_d;
  logic ready_q, ready_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic lock_stable, lock_loss, trig;
  lock_sync_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock (
    .CLK_SLOW   (CLK_SLOW),
    .RESET_SLOW (RESET_SLOW),
    .LOCK_IN    (LOCK_IN),
    .lock_stable(lock_stable)
  );
  always_comb begin
    lock_loss = !lock_stable && (state_q == ST_RELEASE || state_q == ST_RUN);
    trig = SW_RESET_REQ || lock_loss;
    state_d = trig ? ST_HOLD
      : (state_q == ST_HOLD && hold_q == HW'(1)) ? ST_WAIT_LOCK
      : (state_q == ST_WAIT_LOCK && lock_stable) ? ST_RELEASE
      : (state_q == ST_RELEASE && rel_q == RW'(REL_LAST)) ? ST_RUN
      : state_q;
    hold_d = (state_q == ST_HOLD && !trig) ? hold_q - HW'(1) : HW'(HOLD_CYCLES);
    rel_d = (state_q == ST_RELEASE) ? rel_q + RW'(1) : '0;
    for (int k = 0; k < N_CHAN; k++)
      rst_d[k] = (state_d == ST_HOLD) || (rst_q[k] && !(state_d == ST_RELEASE && rel_d == RW'(k * STAGGER_CYCLES)));
    ready_d = state_d == ST_RUN;
    loss_d = (lock_loss && loss_q != LOSS_MAX) ? loss_q + LOSS_W'(1) : loss_q;
  end
  always_ff @(posedge CLK_SLOW) begin
    if (RESET_SLOW) begin
      state_q <= ST_HOLD;
      hold_q  <= HW'(HOLD_CYCLES);
      rel_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end
  assign RESET_OUT = rst_q;
  assign READY = ready_q;
  assign STATE = state_q;
  assign LOCK_LOSS_COUNT = loss_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: timestamp-based reference model feeding a scoreboard checked every cycle
module tb_reset_sequencer;
  localparam int N = 4, H = 8, S = 4, LF = 8;
  logic clk = 1'b0, rst = 1'b1, lock = 1'b0, sw = 1'b0;
  logic [N-1:0] reset_out;
  logic ready;
  logic [1:0] state;
  logic [7:0] llc;
  reset_sequencer #(.N_CHAN(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .LOCK_FILTER(LF)) dut (
    .CLK_SLOW       (clk),
    .RESET_SLOW     (rst),
    .LOCK_IN        (lock),
    .SW_RESET_REQ   (sw),
    .RESET_OUT      (reset_out),
    .READY          (ready),
    .STATE          (state),
    .LOCK_LOSS_COUNT(llc)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [N-1:0] ro;
    logic rdy;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int phase = 0, n = 0, t_hold = 0, t_rel = 0, run = 0, losses = 0;
  bit stable = 0, s_a = 0, s_b = 0;
  always @(posedge clk) begin
    exp_t e;
    bit loss_ev;
    n++;
    if (rst) begin
      phase = 0;
      t_hold = n;
      losses = 0;
      s_a = 0;
      s_b = 0;
      run = 0;
    end else begin
      loss_ev = !stable && phase >= 2;
      if (loss_ev) losses = (losses < 255) ? losses + 1 : 255;
      if (sw || loss_ev) begin
        phase = 0;
        t_hold = n;
      end else if (phase == 0 && n - t_hold == H) phase = 1;
      else if (phase == 1 && stable) begin
        phase = 2;
        t_rel = n;
      end else if (phase == 2 && n - t_rel == (N - 1) * S + 1) phase = 3;
      s_b = s_a;
      s_a = lock;
      run = s_b ? run + 1 : 0;
    end
    stable = run >= LF;
    e.st = 2'(phase);
    e.rdy = phase == 3;
    e.cnt = 8'(losses);
    for (int k = 0; k < N; k++) e.ro[k] = phase < 2 || (phase == 2 && n - t_rel < k * S);
    exp_q.push_back(e);
  end
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({reset_out, ready, state, llc} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got ro=%b rdy=%b st=%0d cnt=%0d, expected ro=%b rdy=%b st=%0d cnt=%0d",
                 $time, reset_out, ready, state, llc, e.ro, e.rdy, e.st, e.cnt);
      end
    end
  end
  task automatic tick(input int c = 1);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_sw();
    sw = 1'b1;
    tick();
    sw = 1'b0;
  endtask
  task automatic wait_phase(input int p, input int budget, input string what);
    int i = 0;
    while (phase != p && i < budget) begin
      tick();
      i++;
    end
    if (phase != p) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: phase=%0d after %0d cycles, expected %0d", what, phase, budget, p);
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    lock = 1'b1;
    tick(3);
    rst = 1'b0;
    wait_phase(3, 40, "powerup");
    tick(3);
    lock = 1'b0;
    pulse_sw();
    wait_phase(1, 20, "late_wait");
    tick(20);
    lock = 1'b1;
    wait_phase(3, 40, "late_run");
    tick(5);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    wait_phase(0, 10, "glitch_hold");
    wait_phase(3, 60, "glitch_run");
    pulse_sw();
    wait_phase(2, 40, "mid_rel");
    tick(S + 1);
    pulse_sw();
    wait_phase(3, 60, "after_sw");
    tick(4);
    lock = 1'b0;
    tick(2);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    lock = 1'b1;
    wait_phase(3, 60, "simul_run");
    for (int i = 0; i < 400; i++) begin
      lock = ($urandom_range(0, 19) != 0);
      sw = ($urandom_range(0, 49) == 0);
      tick();
    end
    sw = 1'b0;
    lock = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_phase(2, 60, "sat_rel");
      tick($urandom_range(0, 16));
      lock = 1'b0;
      tick($urandom_range(1, 3));
      lock = 1'b1;
      wait_phase(0, 10, "sat_hold");
    end
    wait_phase(2, 60, "rst_rel");
    tick($urandom_range(0, 10));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_phase(3, 60, "final_run");
    tick(3);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
